led_seq_monitor: RTL and testbench
==================================

LED_SEQ_MONITOR -- requirements
Module: led_seq_monitor

Interface
REQ-001 Parameter STEP_FAST, default 125_000_000: expected cycles between LED steps when speed_sel=0 (1 s at 125 MHz).
REQ-002 Parameter STEP_SLOW, default 375_000_000: expected cycles between LED steps when speed_sel=1 (3 s).
REQ-003 Parameter TOL, default 16: allowed ± deviation, in cycles, of each measured step interval.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 leds  in  4  LED bus under observation, synchronous to clk.
REQ-007 mode  in  1  0 = Mode A ping-pong (0→1→2→3→2→1→0), 1 = Mode B wrap (0→1→2→3→0).
REQ-008 speed_sel  in  1  selects STEP_FAST (0) or STEP_SLOW (1).
REQ-009 resync  in  1  single-cycle pulse; producer changed mode/speed, monitor must relock.
REQ-010 locked  out  1  high while in TRACK.
REQ-011 step_ok  out  1  one-cycle pulse per correctly sequenced, correctly timed step.
REQ-012 err  out  1  one-cycle pulse on any detected violation.
REQ-013 err_code  out  2  code of last error (01 ONEHOT, 10 SEQUENCE, 11 TIMING); holds until next error.
REQ-014 step_count  out  16  count of step_ok pulses since reset, saturating.

Function
REQ-015 Block SHALL register leds into leds_q each cycle; change = (leds != leds_q).
REQ-016 All outputs SHALL be registered; step_ok/err assert in the cycle after the cycle in which the triggering leds value is present (1-cycle latency).
REQ-017 FSM SHALL have two states: UNLOCKED, TRACK.
REQ-018 UNLOCKED→TRACK in any cycle with leds==4'b0001 and resync low; on entry: dir=up, interval counter cnt=0, expected=4'b0010.
REQ-019 In TRACK, cnt SHALL increment each cycle without change, saturating at 32-bit all-ones, and clear to 0 on each change.
REQ-020 On a change in TRACK, measured interval SHALL be cnt+1, compared against STEP=(speed_sel ? STEP_SLOW : STEP_FAST).
REQ-021 In TRACK, a leds value not exactly one-hot SHALL raise err with code 01 and go UNLOCKED.
REQ-022 A one-hot change not equal to expected SHALL raise err with code 10 and go UNLOCKED.
REQ-023 A correct change with |interval−STEP| > TOL SHALL raise err with code 11 and go UNLOCKED.
REQ-024 If no change occurs and cnt+1 > STEP+TOL, err with code 11 SHALL fire exactly once and the FSM go UNLOCKED.
REQ-025 Priority when multiple violations coincide: ONEHOT > SEQUENCE > TIMING; only one err pulse per cycle.
REQ-026 A correct, in-tolerance change SHALL pulse step_ok, increment step_count (saturate at 16'hFFFF), and compute the next expected value.
REQ-027 Mode A next value: dir up shifts left, dir down shifts right; reaching 4'b1000 sets dir=down, reaching 4'b0001 sets dir=up.
REQ-028 Mode B next value: rotate left, 4'b1000 → 4'b0001; dir ignored.
REQ-029 resync high SHALL force UNLOCKED with no err and no step_ok that cycle; relock follows REQ-018 from the next cycle.
REQ-030 mode or speed_sel changing without resync SHALL take effect on the next step evaluation; no implicit relock.
REQ-031 In UNLOCKED, no err/step_ok SHALL be generated; cnt held at 0.
REQ-032 The immediate relock at 4'b0001 after an error SHALL be permitted (no extra qualification).

Reset
REQ-033 With rst_n low at a clock edge: state=UNLOCKED, leds_q=0, cnt=0, dir=up, locked=0, step_ok=0, err=0, err_code=00, step_count=0.
REQ-034 rst_n low mid-TRACK SHALL abort tracking without err; the first post-reset evaluation follows REQ-018.

Verification (STEP_FAST=10, STEP_SLOW=30, TOL=1)
REQ-035 mode=0, speed_sel=0, leds stepping 0001,0010,0100,1000,0100,0010,0001 every 10 cycles → 6 step_ok, step_count=6, err never set, locked=1 throughout.
REQ-036 mode=1, leds 0001→0010→0100→1000→0001 every 10 cycles → 4 step_ok; then 0001→0100 → err, err_code=10, locked drops next cycle.
REQ-037 Tracking at 0010, leds=0110 → err, err_code=01; leds held 1000 for 12 cycles → single err, err_code=11.
REQ-038 speed_sel=1, steps every 30 cycles pass; steps at 28 or 32 cycles → err, code 11; steps at 29 and 31 → step_ok.
REQ-039 resync pulse mid-sequence, then leds=0001 → no err, locked re-asserts, expected=0010.
REQ-040 Force step_count to 16'hFFFF via long run (or preload in bench) → further steps keep 16'hFFFF; rst_n low one edge → all outputs at REQ-033 values.

Source files
------------

// File: rtl/led_seq_monitor.sv
// led_seq_monitor: locks onto a one-hot LED walk and checks that every step
// follows the selected pattern and arrives within TOL cycles of the nominal period.
module led_seq_monitor #(
   parameter int unsigned STEP_FAST = 125_000_000,
   parameter int unsigned STEP_SLOW = 375_000_000,
   parameter int unsigned TOL       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  leds,
   input  logic        mode,
   input  logic        speed_sel,
   input  logic        resync,
   output logic        locked,
   output logic        step_ok,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] step_count
);

   typedef enum logic {UNLOCKED, TRACK} state_t;

   localparam logic [1:0] E_ONEHOT = 2'b01;
   localparam logic [1:0] E_SEQ    = 2'b10;
   localparam logic [1:0] E_TIME   = 2'b11;

   state_t      state_q, state_d;
   logic [3:0]  leds_q, leds_d;
   logic [31:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;
   logic [3:0]  exp_q, exp_d;
   logic        locked_q, locked_d;
   logic        step_ok_q, step_ok_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [15:0] step_count_q, step_count_d;

   logic        change;
   logic        onehot;
   logic [33:0] step_w;
   logic [33:0] tol_w;
   logic [33:0] ival_w;
   logic        too_long;
   logic        too_short;
   logic [31:0] cnt_inc;
   logic [15:0] count_inc;

   // 34-bit math keeps STEP+TOL and cnt+1 free of wraparound
   always_comb begin
      change    = (leds != leds_q);
      onehot    = $onehot(leds);
      step_w    = speed_sel ? 34'(STEP_SLOW) : 34'(STEP_FAST);
      tol_w     = 34'(TOL);
      ival_w    = {2'b00, cnt_q} + 34'd1;
      too_long  = ival_w > (step_w + tol_w);
      too_short = (ival_w + tol_w) < step_w;
      cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      count_inc = (&step_count_q) ? step_count_q
                                  : step_count_q + 16'd1;
   end

   always_comb begin
      state_d      = state_q;
      leds_d       = leds;
      cnt_d        = cnt_q;
      dir_d        = dir_q;
      exp_d        = exp_q;
      step_ok_d    = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      step_count_d = step_count_q;

      if (resync) begin
         state_d = UNLOCKED;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            UNLOCKED: begin
               cnt_d = '0;
               if (leds == 4'b0001) begin
                  state_d = TRACK;
                  dir_d   = 1'b1;
                  exp_d   = 4'b0010;
               end
            end
            TRACK: begin
               if (change) begin
                  cnt_d = '0;
                  if (!onehot) begin
                     state_d    = UNLOCKED;
                     err_d      = 1'b1;
                     err_code_d = E_ONEHOT;
                  end else if (leds != exp_q) begin
                     state_d    = UNLOCKED;
                     err_d      = 1'b1;
                     err_code_d = E_SEQ;
                  end else if (too_long || too_short) begin
                     state_d    = UNLOCKED;
                     err_d      = 1'b1;
                     err_code_d = E_TIME;
                  end else begin
                     step_ok_d    = 1'b1;
                     step_count_d = count_inc;
                     if (mode) begin
                        exp_d = {leds[2:0], leds[3]};
                     end else if (leds == 4'b1000) begin
                        dir_d = 1'b0;
                        exp_d = 4'b0100;
                     end else if (leds == 4'b0001) begin
                        dir_d = 1'b1;
                        exp_d = 4'b0010;
                     end else begin
                        exp_d = dir_q ? {leds[2:0], 1'b0}
                                      : {1'b0, leds[3:1]};
                     end
                  end
               end else if (too_long) begin
                  // stalled walk: leaving TRACK makes this fire only once
                  state_d    = UNLOCKED;
                  cnt_d      = '0;
                  err_d      = 1'b1;
                  err_code_d = E_TIME;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end

      locked_d = (state_d == TRACK);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= UNLOCKED;
         leds_q       <= '0;
         cnt_q        <= '0;
         dir_q        <= 1'b1;
         exp_q        <= 4'b0010;
         locked_q     <= 1'b0;
         step_ok_q    <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'b00;
         step_count_q <= '0;
      end else begin
         state_q      <= state_d;
         leds_q       <= leds_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         exp_q        <= exp_d;
         locked_q     <= locked_d;
         step_ok_q    <= step_ok_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         step_count_q <= step_count_d;
      end
   end

   assign locked     = locked_q;
   assign step_ok    = step_ok_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_led_seq_monitor.sv
// tb_led_seq_monitor: directed vectors for led_seq_monitor with STEP 10/30, TOL 1,
// plus a one-cycle-step instance used to reach step_count saturation.
module tb_led_seq_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  leds;
   logic        mode;
   logic        speed_sel;
   logic        resync;

   logic        locked, step_ok, err;
   logic [1:0]  err_code;
   logic [15:0] step_count;

   logic        s_locked, s_step_ok, s_err;
   logic [1:0]  s_code;
   logic [15:0] s_count;

   int n_chk = 0;
   int n_bad = 0;
   int n_ok, n_err, n_unl, n_serr;

   always #5 clk = ~clk;

   led_seq_monitor #(
      .STEP_FAST(10), .STEP_SLOW(30), .TOL(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .leds(leds),
      .mode(mode), .speed_sel(speed_sel), .resync(resync),
      .locked(locked), .step_ok(step_ok), .err(err),
      .err_code(err_code), .step_count(step_count)
   );

   led_seq_monitor #(
      .STEP_FAST(1), .STEP_SLOW(1), .TOL(0)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .leds(leds),
      .mode(mode), .speed_sel(speed_sel), .resync(resync),
      .locked(s_locked), .step_ok(s_step_ok), .err(s_err),
      .err_code(s_code), .step_count(s_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (step_ok) n_ok++;
      if (err) n_err++;
      if (!locked) n_unl++;
      if (s_err) n_serr++;
   endtask

   task automatic clr();
      n_ok = 0; n_err = 0; n_unl = 0; n_serr = 0;
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      leds = v;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      leds = 4'b0000;
      resync = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      clr();
   endtask

   initial begin
      rst_n = 1'b0; leds = '0; mode = 1'b0;
      speed_sel = 1'b0; resync = 1'b0;
      clr();

      // reset values
      repeat (2) tick();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_step_ok", 32'(step_ok), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      chk("rst_count", 32'(step_count), 32'd0);

      // ping-pong, fast
      do_reset();
      mode = 1'b0; speed_sel = 1'b0;
      hold(4'b0001, 10); hold(4'b0010, 10);
      hold(4'b0100, 10); hold(4'b1000, 10);
      hold(4'b0100, 10); hold(4'b0010, 10);
      hold(4'b0001, 1);
      chk("pp_ok", 32'(n_ok), 32'd6);
      chk("pp_count", 32'(step_count), 32'd6);
      chk("pp_err", 32'(n_err), 32'd0);
      chk("pp_unlocked", 32'(n_unl), 32'd0);

      // wrap mode then a skipped position
      do_reset();
      mode = 1'b1;
      hold(4'b0001, 10); hold(4'b0010, 10);
      hold(4'b0100, 10); hold(4'b1000, 10);
      hold(4'b0001, 10);
      chk("wr_ok", 32'(n_ok), 32'd4);
      chk("wr_err0", 32'(n_err), 32'd0);
      hold(4'b0100, 1);
      chk("seq_err", 32'(err), 32'd1);
      chk("seq_code", 32'(err_code), 32'd2);
      chk("seq_locked", 32'(locked), 32'd0);
      chk("seq_count", 32'(step_count), 32'd4);
      tick();
      chk("seq_err_once", 32'(err), 32'd0);

      // non-one-hot, then a stalled walk
      do_reset();
      mode = 1'b0;
      hold(4'b0001, 10); hold(4'b0010, 10);
      hold(4'b0110, 1);
      chk("oh_err", 32'(err), 32'd1);
      chk("oh_code", 32'(err_code), 32'd1);
      hold(4'b0001, 10); hold(4'b0010, 10);
      hold(4'b0100, 10);
      clr();
      hold(4'b1000, 12);
      chk("to_none_yet", 32'(n_err), 32'd0);
      chk("to_step", 32'(n_ok), 32'd1);
      tick();
      chk("to_err", 32'(err), 32'd1);
      repeat (8) tick();
      chk("to_once", 32'(n_err), 32'd1);
      chk("to_code", 32'(err_code), 32'd3);

      // slow speed tolerance edges
      do_reset();
      mode = 1'b0; speed_sel = 1'b1;
      hold(4'b0001, 30); hold(4'b0010, 29);
      hold(4'b0100, 31); hold(4'b1000, 28);
      chk("sl_ok", 32'(n_ok), 32'd3);
      chk("sl_err0", 32'(n_err), 32'd0);
      hold(4'b0100, 1);
      chk("sl_short_err", 32'(err), 32'd1);
      chk("sl_short_code", 32'(err_code), 32'd3);
      clr();
      hold(4'b0001, 32);
      chk("sl_wait_err", 32'(n_err), 32'd0);
      hold(4'b0010, 1);
      chk("sl_long_err", 32'(err), 32'd1);
      chk("sl_long_code", 32'(err_code), 32'd3);
      chk("sl_count", 32'(step_count), 32'd3);
      speed_sel = 1'b0;

      // resync mid-sequence
      do_reset();
      mode = 1'b0;
      hold(4'b0001, 10); hold(4'b0010, 5);
      clr();
      resync = 1'b1;
      tick();
      resync = 1'b0;
      chk("rs_locked", 32'(locked), 32'd0);
      chk("rs_err", 32'(err), 32'd0);
      chk("rs_step", 32'(step_ok), 32'd0);
      hold(4'b0001, 1);
      chk("rs_relock", 32'(locked), 32'd1);
      hold(4'b0001, 9);
      hold(4'b0010, 1);
      chk("rs_next_ok", 32'(step_ok), 32'd1);
      chk("rs_no_err", 32'(n_err), 32'd0);

      // saturation on the one-cycle instance
      do_reset();
      mode = 1'b1;
      hold(4'b0001, 1);
      for (int i = 0; i < 65535; i++) begin
         leds = {leds[2:0], leds[3]};
         tick();
      end
      chk("sat_count", 32'(s_count), 32'hFFFF);
      chk("sat_no_err", 32'(n_serr), 32'd0);
      for (int i = 0; i < 2; i++) begin
         leds = {leds[2:0], leds[3]};
         tick();
      end
      chk("sat_step", 32'(s_step_ok), 32'd1);
      chk("sat_hold", 32'(s_count), 32'hFFFF);
      chk("sat_locked", 32'(s_locked), 32'd1);

      // single reset edge
      rst_n = 1'b0;
      tick();
      chk("r2_s_count", 32'(s_count), 32'd0);
      chk("r2_s_locked", 32'(s_locked), 32'd0);
      chk("r2_s_step", 32'(s_step_ok), 32'd0);
      chk("r2_locked", 32'(locked), 32'd0);
      chk("r2_err", 32'(err), 32'd0);
      chk("r2_code", 32'(err_code), 32'd0);
      chk("r2_count", 32'(step_count), 32'd0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
